// File: rtl/reaction_score_keeper.sv
// rtl/reaction_score_keeper.sv - best score, recent-score history and BCD attempt counter
//
// Purpose: consumes finished reaction times (3-digit BCD, 10 ms units) and keeps
// the best accepted score, a ring buffer of the most recent accepted scores and
// a two-digit BCD count of accepted attempts. Single clock, synchronous reset.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-high reset
//   score_valid  in   one-cycle strobe, score_bcd holds a finished run time
//   score_bcd    in   {hundreds, tens, units} BCD reaction time
//   clear_best   in   level, clears the best score only
//   hist_sel     in   history index, 0 = most recent accepted score
//   best_bcd     out  lowest accepted score, 12'h999 when none
//   best_valid   out  a score was accepted since reset/clear_best
//   new_best     out  pulse: last accepted score set a new best
//   rejected     out  pulse: last strobe was rejected
//   hist_bcd     out  registered history entry selected by hist_sel
//   hist_hit     out  selected entry holds a real score
//   attempts_bcd out  two-digit BCD count of accepted scores
//   hist_count   out  number of valid history entries, saturates at HIST_DEPTH

module reaction_score_keeper #(
    parameter int          HIST_DEPTH = 4,
    parameter logic [11:0] MIN_SCORE  = 12'h010,
    localparam int         PW         = $clog2(HIST_DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          score_valid,
    input  logic [11:0]   score_bcd,
    input  logic          clear_best,
    input  logic [PW-1:0] hist_sel,
    output logic [11:0]   best_bcd,
    output logic          best_valid,
    output logic          new_best,
    output logic          rejected,
    output logic [11:0]   hist_bcd,
    output logic          hist_hit,
    output logic [7:0]    attempts_bcd,
    output logic [PW:0]   hist_count
);

    localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(HIST_DEPTH);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [11:0]   r_mem [HIST_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW:0]   r_hist_count;
    logic [11:0]   r_best;
    logic          r_best_valid;
    logic          r_new_best;
    logic          r_rejected;
    logic [11:0]   r_hist_bcd;
    logic          r_hist_hit;
    logic [7:0]    r_attempts;

    logic          w_digits_ok;
    logic          w_accept;
    logic [11:0]   w_base_best;
    logic          w_base_valid;
    logic          w_improve;
    logic [7:0]    w_att_next;
    logic [PW-1:0] w_rd_idx;
    logic          w_hit;

    always_comb begin
        w_digits_ok = (score_bcd[11:8] <= 4'd9) && (score_bcd[7:4] <= 4'd9) &&
                      (score_bcd[3:0] <= 4'd9);
        // With every digit in 0..9 the binary order equals the BCD order.
        w_accept    = score_valid && w_digits_ok && (score_bcd >= MIN_SCORE);

        // clear_best is applied before the incoming score is compared, so a
        // simultaneous accept always becomes the new best.
        w_base_best  = clear_best ? 12'h999 : r_best;
        w_base_valid = clear_best ? 1'b0 : r_best_valid;
        w_improve    = w_accept && (!w_base_valid || (score_bcd < w_base_best));

        w_att_next = r_attempts;
        if (r_attempts[3:0] == 4'd9) begin
            w_att_next[3:0] = 4'd0;
            w_att_next[7:4] = (r_attempts[7:4] == 4'd9) ? 4'd0 : r_attempts[7:4] + 4'd1;
        end else begin
            w_att_next[3:0] = r_attempts[3:0] + 4'd1;
        end

        // (wptr - 1 - sel) mod 2^PW == wptr + ~sel
        w_rd_idx = r_wptr + ~hist_sel;
        w_hit    = ({1'b0, hist_sel} < r_hist_count);
    end

    // History storage needs no reset; stale entries are masked by hist_count.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_mem[r_wptr] <= score_bcd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr       <= '0;
            r_hist_count <= '0;
            r_best       <= 12'h999;
            r_best_valid <= 1'b0;
            r_new_best   <= 1'b0;
            r_rejected   <= 1'b0;
            r_hist_bcd   <= 12'h000;
            r_hist_hit   <= 1'b0;
            r_attempts   <= 8'h00;
        end else begin
            r_new_best <= w_improve;
            r_rejected <= score_valid && !w_accept;

            if (w_improve) begin
                r_best       <= score_bcd;
                r_best_valid <= 1'b1;
            end else begin
                r_best       <= w_base_best;
                r_best_valid <= w_base_valid;
            end

            if (w_accept) begin
                r_wptr     <= r_wptr + PTR_ONE;
                r_attempts <= w_att_next;
                if (r_hist_count != DEPTH_CNT) begin
                    r_hist_count <= r_hist_count + CNT_ONE;
                end
            end

            r_hist_hit <= w_hit;
            r_hist_bcd <= w_hit ? r_mem[w_rd_idx] : 12'h000;
        end
    end

    assign best_bcd     = r_best;
    assign best_valid   = r_best_valid;
    assign new_best     = r_new_best;
    assign rejected     = r_rejected;
    assign hist_bcd     = r_hist_bcd;
    assign hist_hit     = r_hist_hit;
    assign attempts_bcd = r_attempts;
    assign hist_count   = r_hist_count;

endmodule

// File: tb/tb_reaction_score_keeper.sv
// tb/tb_reaction_score_keeper.sv - scoreboard bench for reaction_score_keeper

module tb_reaction_score_keeper;

    localparam int DEPTH = 4;
    localparam int PW    = 2;
    localparam int VW    = 12 + 1 + 1 + 1 + 8 + PW + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          score_valid = 1'b0;
    logic [11:0]   score_bcd = 12'h000;
    logic          clear_best = 1'b0;
    logic [PW-1:0] hist_sel = '0;
    logic [11:0]   best_bcd;
    logic          best_valid;
    logic          new_best;
    logic          rejected;
    logic [11:0]   hist_bcd;
    logic          hist_hit;
    logic [7:0]    attempts_bcd;
    logic [PW:0]   hist_count;

    int passed = 0;
    int total  = 0;

    logic [VW-1:0] exp_q [$];
    logic          mon_sv;
    logic [VW-1:0] mon_exp;
    logic [VW-1:0] mon_act;

    logic [11:0] m_best;
    logic        m_bv;
    int          m_att;
    logic [11:0] m_hist [$];

    reaction_score_keeper #(.HIST_DEPTH(DEPTH), .MIN_SCORE(12'h010)) dut (
        .clock(clock), .reset(reset), .score_valid(score_valid), .score_bcd(score_bcd),
        .clear_best(clear_best), .hist_sel(hist_sel), .best_bcd(best_bcd),
        .best_valid(best_valid), .new_best(new_best), .rejected(rejected),
        .hist_bcd(hist_bcd), .hist_hit(hist_hit), .attempts_bcd(attempts_bcd),
        .hist_count(hist_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    function automatic logic [7:0] to_bcd(input int a);
        return {4'(a / 10), 4'(a % 10)};
    endfunction

    // Scoreboard: every strobe edge outside reset pops one expected result.
    always @(posedge clock) begin
        mon_sv = score_valid && !reset;
        #1;
        if (mon_sv) begin
            total++;
            mon_act = {best_bcd, best_valid, new_best, rejected, attempts_bcd, hist_count};
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: got %h, no expected entry", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp)
                    $display("FAIL strobe_result: got best=%h bv=%b nb=%b rej=%b att=%h cnt=%0d, expected best=%h bv=%b nb=%b rej=%b att=%h cnt=%0d",
                             best_bcd, best_valid, new_best, rejected, attempts_bcd, hist_count,
                             mon_exp[VW-1 -: 12], mon_exp[VW-13], mon_exp[VW-14], mon_exp[VW-15],
                             mon_exp[PW+8 -: 8], mon_exp[PW:0]);
                else
                    passed++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_best = 12'h999;
        m_bv   = 1'b0;
        m_att  = 0;
        m_hist.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [11:0] s, input logic clr);
        logic acc, nb;
        acc = (s[11:8] <= 4'd9) && (s[7:4] <= 4'd9) && (s[3:0] <= 4'd9) && (s >= 12'h010);
        nb  = 1'b0;
        if (clr) begin
            m_best = 12'h999;
            m_bv   = 1'b0;
        end
        if (acc) begin
            m_att = (m_att + 1) % 100;
            m_hist.push_front(s);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
            if (!m_bv || s < m_best) begin
                m_best = s;
                m_bv   = 1'b1;
                nb     = 1'b1;
            end
        end
        exp_q.push_back({m_best, m_bv, nb, !acc, to_bcd(m_att), (PW+1)'(m_hist.size())});
        score_valid = 1'b1;
        score_bcd   = s;
        clear_best  = clr;
        step();
        score_valid = 1'b0;
        clear_best  = 1'b0;
    endtask

    task automatic read_hist(input logic [PW-1:0] sel);
        hist_sel = sel;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({best_bcd, best_valid, new_best, rejected, attempts_bcd, hist_count, hist_bcd, hist_hit} !==
            {12'h999, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 12'h000, 1'b0})
            $display("FAIL reset_state: got best=%h bv=%b nb=%b rej=%b att=%h cnt=%0d hist=%h hit=%b, expected 999/0/0/0/00/0/000/0",
                     best_bcd, best_valid, new_best, rejected, attempts_bcd, hist_count, hist_bcd, hist_hit);
        else passed++;
    endtask

    task automatic test_single();
        send(12'h245, 1'b0);
        read_hist(2'd0);
        total++;
        if ({hist_bcd, hist_hit, new_best} !== {12'h245, 1'b1, 1'b0})
            $display("FAIL single_read: got hist=%h hit=%b nb=%b, expected 245/1/0", hist_bcd, hist_hit, new_best);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_h [4];
        exp_h = '{12'h180, 12'h180, 12'h300, 12'h245};
        send(12'h300, 1'b0);
        send(12'h180, 1'b0);
        send(12'h180, 1'b0);
        for (int i = 0; i < 4; i++) begin
            read_hist(PW'(i));
            total++;
            if ({hist_bcd, hist_hit} !== {exp_h[i], 1'b1})
                $display("FAIL b2b_hist%0d: got %h hit=%b, expected %h hit=1", i, hist_bcd, hist_hit, exp_h[i]);
            else passed++;
        end
        total++;
        if ({best_bcd, attempts_bcd, new_best} !== {12'h180, 8'h04, 1'b0})
            $display("FAIL b2b_totals: got best=%h att=%h nb=%b, expected 180/04/0", best_bcd, attempts_bcd, new_best);
        else passed++;
    endtask

    task automatic test_reject();
        send(12'h005, 1'b0);
        send(12'h1A3, 1'b0);
        step();
        total++;
        if ({rejected, best_bcd, attempts_bcd, hist_count} !== {1'b0, 12'h180, 8'h04, 3'd4})
            $display("FAIL reject_after: got rej=%b best=%h att=%h cnt=%0d, expected 0/180/04/4",
                     rejected, best_bcd, attempts_bcd, hist_count);
        else passed++;
    endtask

    task automatic test_clear();
        send(12'h900, 1'b1);
        clear_best = 1'b1;
        m_best = 12'h999;
        m_bv   = 1'b0;
        step();
        clear_best = 1'b0;
        total++;
        if ({best_bcd, best_valid, new_best, attempts_bcd, hist_count} !== {12'h999, 1'b0, 1'b0, 8'h05, 3'd4})
            $display("FAIL clear_alone: got best=%h bv=%b nb=%b att=%h cnt=%0d, expected 999/0/0/05/4",
                     best_bcd, best_valid, new_best, attempts_bcd, hist_count);
        else passed++;
        read_hist(2'd0);
        total++;
        if ({hist_bcd, hist_hit} !== {12'h900, 1'b1})
            $display("FAIL clear_hist: got %h hit=%b, expected 900 hit=1", hist_bcd, hist_hit);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [11:0] exp_h [4];
        exp_h = '{12'h600, 12'h500, 12'h400, 12'h300};
        do_reset();
        read_hist(2'd3);
        total++;
        if ({hist_bcd, hist_hit} !== {12'h000, 1'b0})
            $display("FAIL empty_slot: got %h hit=%b, expected 000 hit=0", hist_bcd, hist_hit);
        else passed++;
        for (int i = 1; i <= 6; i++) send(12'(i) << 8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            read_hist(PW'(i));
            total++;
            if ({hist_bcd, hist_hit, hist_count} !== {exp_h[i], 1'b1, 3'd4})
                $display("FAIL wrap_hist%0d: got %h hit=%b cnt=%0d, expected %h hit=1 cnt=4",
                         i, hist_bcd, hist_hit, hist_count, exp_h[i]);
            else passed++;
        end
    endtask

    task automatic test_attempts_and_reset_strobe();
        logic [7:0] want;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            send(12'h500, 1'b0);
            if (i == 9 || i == 10 || i == 99 || i == 100) begin
                want = (i == 9) ? 8'h09 : (i == 10) ? 8'h10 : (i == 99) ? 8'h99 : 8'h00;
                total++;
                if (attempts_bcd !== want)
                    $display("FAIL attempts_at_%0d: got %h, expected %h", i, attempts_bcd, want);
                else passed++;
            end
        end
        reset       = 1'b1;
        score_valid = 1'b1;
        score_bcd   = 12'h100;
        step();
        reset       = 1'b0;
        score_valid = 1'b0;
        model_reset();
        total++;
        if ({best_bcd, best_valid, new_best, rejected, attempts_bcd, hist_count, hist_bcd, hist_hit} !==
            {12'h999, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 12'h000, 1'b0})
            $display("FAIL reset_with_strobe: got best=%h bv=%b nb=%b rej=%b att=%h cnt=%0d hist=%h hit=%b, expected 999/0/0/0/00/0/000/0",
                     best_bcd, best_valid, new_best, rejected, attempts_bcd, hist_count, hist_bcd, hist_hit);
        else passed++;
    endtask

    initial begin
        model_reset();
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_reject();
        test_clear();
        test_wrap();
        test_attempts_and_reset_strobe();
        step();
        total++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
